// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared types and constants for the immediate generator.
//   imm_type_e    : 3-bit immediate type code (7 = no legal immediate)
//   OP_*          : RV opcode constants used by the auto-decoder
//   imm_payload_t : one buffered result {imm, imm_t, illegal}; imm is held at
//                   the widest supported XLEN (64) and narrowed at the output
// ---------------------------------------------------------------------------
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_ILL = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int IMM_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_type_e            imm_t;
        logic                 illegal;
    } imm_payload_t;

endpackage

// File: rtl/imm_extend_core.sv
// ---------------------------------------------------------------------------
// imm_extend_core
// Purely combinational immediate extractor/extender.
//   inst     in  [31:7]  instruction word without the opcode field
//   imm_type in  3       immediate type code
//   imm      out XLEN    sign/zero-extended immediate (0 for illegal)
//   illegal  out 1       type code had no legal immediate
// ---------------------------------------------------------------------------
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Size casts of signed operands sign-extend; unsigned operands zero-extend.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_type)
            IMM_I:  imm = XLEN'($signed(inst[31:20]));
            IMM_S:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                         inst[11:8], 1'b0}));
            IMM_J:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                         inst[30:21], 1'b0}));
            IMM_U:  imm = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_Z:  imm = XLEN'(inst[19:15]);
            IMM_SH: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate generator with a registered output and a one-entry
// skid register behind it.
//   clk, rst     sole clock; synchronous active-high reset
//   in_valid/in_ready/inst/imm_src    input handshake + word (+ manual type)
//   out_valid/out_ready               output handshake
//   imm_ext, imm_type, imm_illegal    result of the word in the main register
//   illegal_cnt  saturating count of accepted illegal words
//
// Buffer occupancy (main_valid_q, skid_valid_q):
//   state | meaning
//   0,0   | empty, in_ready=1
//   1,0   | one word presented at the output, in_ready=1
//   1,1   | full, in_ready=0 until main drains
// ---------------------------------------------------------------------------
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [2:0]       imm_type,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    imm_type_e       auto_type;
    imm_type_e       sel_type;
    logic [XLEN-1:0] core_imm;
    logic            core_illegal;
    imm_payload_t    new_pl;

    imm_payload_t    main_q, main_d;
    imm_payload_t    skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            drain;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        auto_type = IMM_ILL;
        case (opcode)
            OP_LOAD, OP_JALR: auto_type = IMM_I;
            // shift-immediates carry a shamt, not a 12-bit immediate
            OP_IMM:    auto_type = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
            OP_STORE:  auto_type = IMM_S;
            OP_BRANCH: auto_type = IMM_B;
            OP_JAL:    auto_type = IMM_J;
            OP_LUI, OP_AUIPC: auto_type = IMM_U;
            // funct3[2] selects the CSR*I forms with a 5-bit uimm
            OP_SYSTEM: auto_type = funct3[2] ? IMM_Z : IMM_I;
            default:   auto_type = IMM_ILL;
        endcase
    end

    assign sel_type = AUTO_DECODE ? auto_type : imm_type_e'(imm_src);

    imm_extend_core #(
        .XLEN (XLEN)
    ) u_core (
        .inst     (inst[31:7]),
        .imm_type (sel_type),
        .imm      (core_imm),
        .illegal  (core_illegal)
    );

    always_comb begin
        new_pl         = '0;
        new_pl.imm     = IMM_MAX_W'(core_imm);
        new_pl.imm_t   = sel_type;
        new_pl.illegal = core_illegal;
    end

    // in_ready depends only on registered state, never on out_ready.
    assign accept = in_valid && !skid_valid_q;
    assign drain  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                // accept is impossible here since in_ready is low while skid is full
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_pl;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_pl;
            skid_valid_d = 1'b1;
        end

        if (accept && new_pl.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign imm_ext     = main_q.imm[XLEN-1:0];
    assign imm_type    = main_q.imm_t;
    assign imm_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
